// File: rtl/input_pkg.sv
// Shared constants for the board-input front end: default debounce timing,
// input counts and the button index map used by mode selection.
package input_pkg;

  localparam int unsigned SAMPLE_CYCLES_DEF  = 32'd100000;
  localparam int unsigned STABLE_SAMPLES_DEF = 32'd8;
  localparam int unsigned REPEAT_DELAY_DEF   = 32'd500;
  localparam int unsigned REPEAT_PERIOD_DEF  = 32'd100;
  localparam int unsigned N_BTN_DEF          = 32'd4;
  localparam int unsigned N_SW_DEF           = 32'd16;

  typedef enum logic [1:0] {
    BTN_UP    = 2'd0,
    BTN_DOWN  = 2'd1,
    BTN_LEFT  = 2'd2,
    BTN_RIGHT = 2'd3
  } btn_idx_e;

  // Width of a counter that must hold the values 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: two-flop synchroniser, tick-sampled history and
// the debounced level together with its one-cycle delayed copy.
module debounce_bit #(
  parameter int unsigned STABLE_SAMPLES = 32'd8
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic level_d_o,
  output logic stable_o
);

  logic                      sync1_r;
  logic                      sync2_r;
  logic [STABLE_SAMPLES-1:0] hist_r;
  logic [STABLE_SAMPLES-1:0] hist_next_s;
  logic                      level_r;
  logic                      level_d_r;

  // History as it will look once the current synchronised value is shifted in.
  always_comb begin
    hist_next_s = {hist_r[STABLE_SAMPLES-2:0], sync2_r};
  end

  // Synchroniser; the only logic that ever sees the raw input.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw_i;
      sync2_r <= sync1_r;
    end
  end

  // Sample history and level; any disagreeing sample restarts qualification.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      hist_r  <= '0;
      level_r <= 1'b0;
    end else if (tick_i) begin
      hist_r <= hist_next_s;
      if ((&hist_next_s) && !level_r) begin
        level_r <= 1'b1;
      end else if ((~|hist_next_s) && level_r) begin
        level_r <= 1'b0;
      end else begin
        level_r <= level_r;
      end
    end else begin
      hist_r  <= hist_r;
      level_r <= level_r;
    end
  end

  // Delayed level for edge detection in the parent.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      level_d_r <= 1'b0;
    end else begin
      level_d_r <= level_r;
    end
  end

  assign level_o   = level_r;
  assign level_d_o = level_d_r;
  assign stable_o  = (&hist_r) | (~|hist_r);

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: debounced button/switch levels and event pulses.
// Define INPUT_CONDITIONER_AUTOREPEAT_EN to add held-button auto-repeat presses.
module input_conditioner
  import input_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES  = SAMPLE_CYCLES_DEF,
  parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int unsigned N_BTN          = N_BTN_DEF,
  parameter int unsigned N_SW           = N_SW_DEF,
  parameter int unsigned REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [N_BTN-1:0] buttons_i,
  input  logic [N_SW-1:0]  switches_i,
  output logic [N_BTN-1:0] buttons_level_o,
  output logic [N_BTN-1:0] buttons_press_o,
  output logic [N_BTN-1:0] buttons_release_o,
  output logic [N_SW-1:0]  switches_level_o,
  output logic [N_SW-1:0]  switches_toggle_o,
  output logic             sample_tick_o
);

  localparam int unsigned CNT_W = cnt_width(SAMPLE_CYCLES);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             tick_r;
  logic             tick_d_r;
  logic             init_r;

  logic [N_BTN-1:0] btn_lvl_s;
  logic [N_BTN-1:0] btn_lvl_d_s;
  logic [N_BTN-1:0] unused_btn_stable_s;
  logic [N_BTN-1:0] rep_s;
  logic [N_SW-1:0]  sw_lvl_s;
  logic [N_SW-1:0]  sw_lvl_d_s;
  logic [N_SW-1:0]  sw_stable_s;

  // Next value of the free-running sample counter.
  always_comb begin
    if (count_r == CNT_W'(SAMPLE_CYCLES - 32'd1)) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_r + CNT_W'(1);
    end
  end

  // Tick is registered from the next count so it is high while count == SAMPLE_CYCLES-1.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      count_r  <= '0;
      tick_r   <= 1'b0;
      tick_d_r <= 1'b0;
    end else begin
      count_r  <= count_next_s;
      tick_r   <= (count_next_s == CNT_W'(SAMPLE_CYCLES - 32'd1));
      tick_d_r <= tick_r;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_db (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .raw_i     (buttons_i[i]),
      .tick_i    (tick_r),
      .level_o   (btn_lvl_s[i]),
      .level_d_o (btn_lvl_d_s[i]),
      .stable_o  (unused_btn_stable_s[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_db (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .raw_i     (switches_i[i]),
      .tick_i    (tick_r),
      .level_o   (sw_lvl_s[i]),
      .level_d_o (sw_lvl_d_s[i]),
      .stable_o  (sw_stable_s[i])
    );
  end

  // Set one cycle after the first tick leaving every switch history uniform, so the
  // initial level load lands while toggles are still masked.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      init_r <= 1'b0;
    end else if (tick_d_r && (&sw_stable_s)) begin
      init_r <= 1'b1;
    end else begin
      init_r <= init_r;
    end
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned REP_W = cnt_width(REPEAT_DELAY + REPEAT_PERIOD);

  logic [N_BTN-1:0] rep_r;

  for (genvar i = 0; i < N_BTN; i++) begin : g_rep
    logic [REP_W-1:0] rep_cnt_r;

    // Ticks held since qualification; folds back by one period after each repeat.
    always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
        rep_cnt_r <= '0;
        rep_r[i]  <= 1'b0;
      end else if (!btn_lvl_s[i]) begin
        rep_cnt_r <= '0;
        rep_r[i]  <= 1'b0;
      end else if (tick_r) begin
        if (rep_cnt_r == REP_W'(REPEAT_DELAY + REPEAT_PERIOD - 32'd1)) begin
          rep_cnt_r <= REP_W'(REPEAT_DELAY);
          rep_r[i]  <= 1'b1;
        end else begin
          rep_cnt_r <= rep_cnt_r + REP_W'(1);
          rep_r[i]  <= (rep_cnt_r == REP_W'(REPEAT_DELAY - 32'd1));
        end
      end else begin
        rep_cnt_r <= rep_cnt_r;
        rep_r[i]  <= 1'b0;
      end
    end
  end

  assign rep_s = rep_r;
`else
  localparam int unsigned unused_rep_cfg = REPEAT_DELAY + REPEAT_PERIOD;

  assign rep_s = '0;
`endif

  // Repeat pulses are masked by the live level so a release cancels them at once.
  assign buttons_level_o   = btn_lvl_s;
  assign buttons_press_o   = (btn_lvl_s & ~btn_lvl_d_s) | (rep_s & btn_lvl_s);
  assign buttons_release_o = ~btn_lvl_s & btn_lvl_d_s;
  assign switches_level_o  = sw_lvl_s;
  assign switches_toggle_o = (sw_lvl_s ^ sw_lvl_d_s) & {N_SW{init_r}};
  assign sample_tick_o     = tick_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a run-length
// behavioural model; honours INPUT_CONDITIONER_AUTOREPEAT_EN when defined.
module tb_input_conditioner;

  localparam int SC = 4;
  localparam int S  = 3;
  localparam int RD = 5;
  localparam int RP = 2;
  localparam int NB = 4;
  localparam int NS = 16;
  localparam int NT = NB + NS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic [NS-1:0] sw;
  logic [NB-1:0] buttons_level_o, buttons_press_o, buttons_release_o;
  logic [NS-1:0] switches_level_o, switches_toggle_o;
  logic          sample_tick_o;

  always #5 clk = ~clk;

  input_conditioner #(
    .SAMPLE_CYCLES(SC), .STABLE_SAMPLES(S), .N_BTN(NB), .N_SW(NS),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock_i           (clk),
    .reset_i           (rst_n),
    .buttons_i         (btn),
    .switches_i        (sw),
    .buttons_level_o   (buttons_level_o),
    .buttons_press_o   (buttons_press_o),
    .buttons_release_o (buttons_release_o),
    .switches_level_o  (switches_level_o),
    .switches_toggle_o (switches_toggle_o),
    .sample_tick_o     (sample_tick_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges since release, a two-cycle input delay, and per-bit
  // runs of identical tick samples (reset history counts as a run of zeros).
  int            edges;
  logic [NT-1:0] dly[$];
  logic [NT-1:0] run_val, lvl, lvl_prev;
  int            run_len[NT];
  int            held[NB];
  logic [NB-1:0] rep;
  logic          init_f, pend;

  // Observed event counters for directed checks.
  int press_cnt[NB], rel_cnt[NB];
  int tog_total, tog_bit3, both_rel;

  task automatic model_reset();
    edges = 0;
    dly.delete();
    dly.push_back('0);
    dly.push_back('0);
    run_val = '0; lvl = '0; lvl_prev = '0; rep = '0;
    init_f = 1'b0; pend = 1'b0;
    for (int b = 0; b < NT; b++) run_len[b] = S;
    for (int b = 0; b < NB; b++) held[b] = 0;
  endtask

  task automatic clear_counts();
    for (int b = 0; b < NB; b++) begin press_cnt[b] = 0; rel_cnt[b] = 0; end
    tog_total = 0; tog_bit3 = 0; both_rel = 0;
  endtask

  task automatic model_edge();
    logic          tick;
    logic [NT-1:0] v;
    if (!rst_n) return;
    tick = ((edges % SC) == SC - 1);
    edges++;
    v = dly.pop_front();
    dly.push_back({sw, btn});
    lvl_prev = lvl;
    if (pend) init_f = 1'b1;
    pend = 1'b0;
    rep = '0;
    if (tick) begin
      for (int b = 0; b < NT; b++) begin
        if (v[b] == run_val[b]) begin
          if (run_len[b] < S) run_len[b]++;
        end else begin
          run_val[b] = v[b];
          run_len[b] = 1;
        end
        if (run_len[b] >= S) lvl[b] = run_val[b];
      end
      for (int b = 0; b < NB; b++) begin
        if (lvl_prev[b] && lvl[b]) begin
          held[b]++;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
          if (held[b] == RD || (held[b] > RD && ((held[b] - RD) % RP) == 0)) rep[b] = 1'b1;
`endif
        end else begin
          held[b] = 0;
        end
      end
      pend = 1'b1;
      for (int b = NB; b < NT; b++) if (run_len[b] < S) pend = 1'b0;
    end
  endtask

  task automatic compare();
    logic [NT-1:0] rise, fall;
    logic [NS-1:0] tog;
    rise = lvl & ~lvl_prev;
    fall = ~lvl & lvl_prev;
    tog  = init_f ? (lvl[NT-1:NB] ^ lvl_prev[NT-1:NB]) : '0;
    check_eq("btn_level",   buttons_level_o,   lvl[NB-1:0]);
    check_eq("btn_press",   buttons_press_o,   rise[NB-1:0] | rep);
    check_eq("btn_release", buttons_release_o, fall[NB-1:0]);
    check_eq("sw_level",    switches_level_o,  lvl[NT-1:NB]);
    check_eq("sw_toggle",   switches_toggle_o, tog);
    check_eq("tick",        sample_tick_o,     rst_n && ((edges % SC) == SC - 1));
    for (int b = 0; b < NB; b++) begin
      if (buttons_press_o[b])   press_cnt[b]++;
      if (buttons_release_o[b]) rel_cnt[b]++;
    end
    if (switches_toggle_o != '0) tog_total++;
    if (switches_toggle_o[3])    tog_bit3++;
    if (buttons_release_o[1] && buttons_release_o[3]) both_rel++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 compare();
    step(hold);
    rst_n = 1'b1;
    #1 compare();
  endtask

  initial begin
    int seen;
    int idx;
    rst_n = 1'b1; btn = '0; sw = '0;
    clear_counts();
    model_reset();
    #2 rst_n = 1'b0;
    #1 compare();
    step(40);
    rst_n = 1'b1;
    step(20);

    // Clean press on button 0.
    clear_counts();
    btn[0] = 1'b1;
    step(25);
    check_eq("btn0_one_press", press_cnt[0], 1);
    check_eq("btn0_no_release", rel_cnt[0], 0);
    btn[0] = 1'b0;
    step(25);

    // Sample-aligned bounce on button 2, then a clean qualification.
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      btn[2] = (k % 2 == 0);
      step(SC);
    end
    btn[2] = 1'b0;
    step(20);
    check_eq("btn2_bounce_press", press_cnt[2], 0);
    check_eq("btn2_bounce_level", buttons_level_o[2], 0);
    btn[2] = 1'b1;
    step(25);
    check_eq("btn2_settled_press", press_cnt[2], 1);
    btn[2] = 1'b0;
    step(25);

    // Switches already set at release come up silently; then flip bit 3.
    sw = 16'hA5A5;
    do_reset(5);
    clear_counts();
    step(30);
    check_eq("sw_a5a5_level", switches_level_o, 16'hA5A5);
    check_eq("sw_a5a5_no_toggle", tog_total, 0);
    sw[3] = ~sw[3];
    step(25);
    check_eq("sw3_one_toggle", tog_bit3, 1);
    check_eq("sw_only_bit3", tog_total, 1);

    // Buttons 1 and 3 released together, then reset during qualification.
    btn[1] = 1'b1; btn[3] = 1'b1;
    step(25);
    clear_counts();
    btn[1] = 1'b0; btn[3] = 1'b0;
    step(25);
    check_eq("btn13_same_cycle_release", both_rel, 1);
    btn[1] = 1'b1;
    step(2 * SC);
    do_reset(3);
    clear_counts();
    step(30);
    check_eq("btn1_press_after_reset", press_cnt[1], 1);
    btn[1] = 1'b0;
    step(25);

    // Random activity with varied hold times.
    for (int n = 0; n < 40; n++) begin
      btn = NB'($urandom);
      idx = $urandom_range(NS - 1, 0);
      sw[idx] = ~sw[idx];
      if (($urandom % 8) == 0) sw = NS'($urandom);
      step($urandom_range(24, 1));
    end
    btn = '0;
    step(30);

    // Long hold on button 0: count presses in the 47 cycles after qualification.
    btn[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      step(1);
      if (buttons_press_o[0]) seen = 1;
    end
    check_eq("btn0_qualified", seen, 1);
    clear_counts();
    step(47);
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    check_eq("btn0_repeats", press_cnt[0], 4);
`else
    check_eq("btn0_repeats", press_cnt[0], 0);
`endif
    btn[0] = 1'b0;
    step(30);
    clear_counts();
    step(30);
    check_eq("btn0_no_press_after_release", press_cnt[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Receive-side front end for the raw board inputs: four push-buttons and sixteen slide switches.
- Synchronises each input to `clock_i`, debounces it with a shared sample strobe, and produces clean levels plus single-cycle event pulses.
- Feeds mode selection and whack detection in place of raw `buttons_i`/`switches_i`.
- It is the input counterpart of the display-drive path.

Parameters:
- `SAMPLE_CYCLES`, 100000, clock cycles between debounce samples (1 ms at 100 MHz).
- `STABLE_SAMPLES`, 8, consecutive agreeing samples needed to accept a new level (2..16).
- `N_BTN`, 4, number of button inputs.
- `N_SW`, 16, number of switch inputs.
- `REPEAT_DELAY`, 500, samples a button is held before the first auto-repeat (feature only).
- `REPEAT_PERIOD`, 100, samples between subsequent auto-repeats (feature only).

Ports:
- `clock_i`  in  1  system clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `buttons_i`  in  N_BTN  raw, asynchronous button inputs.
- `switches_i`  in  N_SW  raw, asynchronous switch inputs.
- `buttons_level_o`  out  N_BTN  debounced button levels.
- `buttons_press_o`  out  N_BTN  one-cycle pulse per debounced 0->1 (and per auto-repeat).
- `buttons_release_o`  out  N_BTN  one-cycle pulse per debounced 1->0.
- `switches_level_o`  out  N_SW  debounced switch levels.
- `switches_toggle_o`  out  N_SW  one-cycle pulse per debounced change, either direction.
- `sample_tick_o`  out  1  one-cycle strobe each sample instant (debug/bench).

Behaviour:
- Reset: asserting `reset_i` low immediately clears the following to 0:
  - all outputs;
  - synchroniser flops and sample histories;
  - the tick counter;
  - the switch-initialised flag.
- Synchroniser: two flops per input bit; nothing else touches raw inputs.
- Tick counter:
  - Counts 0..SAMPLE_CYCLES-1, then wraps to 0.
  - `sample_tick_o` is high in the cycle where count == SAMPLE_CYCLES-1.
  - First tick occurs SAMPLE_CYCLES cycles after reset release.
- History: on each tick, every bit shifts its synchronised value into a STABLE_SAMPLES-deep history register.
- Level update: on the tick edge, per bit:
  - history all ones and level 0 -> level 1;
  - history all zeros and level 1 -> level 0;
  - otherwise level holds, so a single disagreeing sample restarts qualification.
- Event pulses:
  - Combinational from level vs. a one-cycle delayed copy: press = level & ~level_d, release = ~level & level_d, toggle = level ^ level_d.
  - Each pulse is exactly one cycle wide, in the cycle after the level change.
- Latency: a clean raw edge reaches the level after 2 cycles + STABLE_SAMPLES ticks, ± one tick of phase (worst case 2 + (STABLE_SAMPLES+1)*SAMPLE_CYCLES cycles).
- Switch initialisation:
  - After reset, `switches_toggle_o` is suppressed until the first time every switch bit has a uniform history. That tick sets the initialised flag.
  - Switches already high at reset release come up on `switches_level_o` with no toggle pulse.
  - Buttons have no such suppression: a button held through reset release gives one press pulse once debounced.
- Simultaneous events: bits are fully independent; several press/release/toggle pulses may assert in the same cycle.
- Reset mid-qualification: history is discarded, and qualification restarts from zero after release.
- Bounce shorter than STABLE_SAMPLES samples: no level change, no pulse.

Optional Feature:
- Macro `INPUT_CONDITIONER_AUTOREPEAT_EN`.
- Defined:
  - Each button has a repeat counter in sample ticks, cleared whenever its level is 0.
  - While held, an extra one-cycle press pulse fires after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks.
  - Releasing the button cancels repeats immediately.
- Undefined: counters are absent; press fires only on the 0->1 transition.
- Switch behaviour is identical either way.

Decomposition:
- Shared package `input_pkg`:
  - default SAMPLE_CYCLES/STABLE_SAMPLES;
  - N_BTN/N_SW;
  - the button index constants (BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT) used by mode selection.
- Sub-module `debounce_bit`:
  - Holds the synchroniser, history, level and delayed level for one bit.
  - Takes the shared tick in; outputs level and level_d.
- The top generates N_BTN + N_SW instances plus one tick counter and the optional repeat logic.

Test Plan (SAMPLE_CYCLES=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_PERIOD=2):
- Reset with all inputs 0, hold 40 cycles -> all outputs 0; `sample_tick_o` first high 4 cycles after release, then every 4 cycles.
- `buttons_i[0]` 0->1 clean -> `buttons_level_o[0]` rises within 2+16 cycles; `buttons_press_o[0]` high exactly 1 cycle; no release pulse.
- `buttons_i[2]` bounces 1,0,1,0 on successive ticks then settles 0 -> no level change, no pulses; settle at 1 for 3 ticks -> one press pulse.
- `switches_i`=16'hA5A5 at reset release -> `switches_level_o`=16'hA5A5 after debounce, `switches_toggle_o` never asserts; then flip bit 3 -> single toggle pulse on bit 3 only.
- Buttons 1 and 3 released on the same cycle -> both release pulses in the same cycle; assert `reset_i` low mid-qualification -> levels 0 immediately, no pulse.
- With `INPUT_CONDITIONER_AUTOREPEAT_EN`, hold button 0 for 12 ticks after qualification -> press pulses at qualification and after 5, 7, 9, 11 ticks; release -> no further presses.
